// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU (priority) and an
// auxiliary req/ack requester, with a starvation counter that forces one aux
// cycle by stalling the CPU after a bounded wait.
module dmem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] cpu_address,
  input  logic [XLEN-1:0] cpu_write_data,
  input  logic            cpu_write_enable,
  input  logic            cpu_read_enable,
  output logic [XLEN-1:0] cpu_read_data,
  output logic            cpu_stall,
  input  logic            aux_req,
  input  logic [XLEN-1:0] aux_address,
  input  logic [XLEN-1:0] aux_write_data,
  input  logic            aux_write_enable,
  output logic            aux_ack,
  output logic [XLEN-1:0] aux_read_data,
  output logic            aux_error,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_enable,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam int unsigned    CW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0]  LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DEPTH);

  typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   starve_count;
  logic [XLEN-1:0] lat_address;
  logic [XLEN-1:0] lat_data;
  logic            lat_we;
  logic            cpu_access;
  logic            out_of_range;
  logic            grant;
  logic            aux_port;

  assign cpu_access    = cpu_write_enable | cpu_read_enable;
  assign out_of_range  = (lat_address >= DEPTH_W);
  assign grant         = (state == PENDING) &&
                         (!cpu_access || (starve_count == LIMIT) || out_of_range);
  // An out-of-range grant never touches memory, so the CPU keeps the port and
  // is not stalled; only in-range grants take the port.
  assign aux_port      = grant && !out_of_range;
  assign cpu_read_data = mem_read_data;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (aux_req) state_next = PENDING;
      PENDING: if (grant)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port mux, stall and ack outputs
  always_comb begin
    mem_address      = cpu_address;
    mem_write_data   = cpu_write_data;
    mem_write_enable = cpu_write_enable;
    cpu_stall        = 1'b0;
    aux_ack          = (state == DONE);
    if (aux_port) begin
      mem_address      = lat_address;
      mem_write_data   = lat_data;
      mem_write_enable = lat_we;
      cpu_stall        = cpu_access;
    end
  end

  // Request latch, starvation counter and aux result capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_count  <= '0;
      lat_address   <= '0;
      lat_data      <= '0;
      lat_we        <= 1'b0;
      aux_read_data <= '0;
      aux_error     <= 1'b0;
    end else begin
      if (state == IDLE && aux_req) begin
        lat_address  <= aux_address;
        lat_data     <= aux_write_data;
        lat_we       <= aux_write_enable;
        starve_count <= '0;
      end
      if (state == PENDING) begin
        if (grant) begin
          if (!lat_we) aux_read_data <= mem_read_data;
          aux_error <= out_of_range;
        end else if (starve_count != LIMIT) begin
          starve_count <= starve_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a
// scoreboard of expected aux completions.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        cpu_write_enable, cpu_read_enable, cpu_stall;
  logic        aux_req, aux_write_enable, aux_ack, aux_error;
  logic [31:0] aux_address, aux_write_data, aux_read_data;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [31:0] mem [64];
  logic        init_mem;

  dmem_arbiter #(.XLEN(32), .DEPTH(64), .STARVE_LIMIT(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_address      (cpu_address),
    .cpu_write_data   (cpu_write_data),
    .cpu_write_enable (cpu_write_enable),
    .cpu_read_enable  (cpu_read_enable),
    .cpu_read_data    (cpu_read_data),
    .cpu_stall        (cpu_stall),
    .aux_req          (aux_req),
    .aux_address      (aux_address),
    .aux_write_data   (aux_write_data),
    .aux_write_enable (aux_write_enable),
    .aux_ack          (aux_ack),
    .aux_read_data    (aux_read_data),
    .aux_error        (aux_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: synchronous write, combinational read, word 3 preset to 0x1234
  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[3] <= 32'h0000_1234;
    end else if (mem_write_enable && mem_address < 32'd64) begin
      mem[mem_address[5:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = (mem_address < 32'd64) ? mem[mem_address[5:0]] : '0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #2;
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, aux_read_data, e.rdata);
      check({tag, "_err"}, 32'(aux_error), 32'(e.err));
    end
  endtask

  // One aux request with the CPU idle: grant one cycle after acceptance,
  // ack one cycle after that, ack lasts a single cycle.
  task automatic aux_idle(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input logic exp_err);
    int  cyc;
    bit  got;
    exp_t e;
    nxt();
    aux_req = 1'b1; aux_write_enable = we; aux_address = addr; aux_write_data = data;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    cyc = 0; got = 0;
    while (!got && cyc < 12) begin
      nxt();
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_grant_we"}, 32'(mem_write_enable), 32'(we && addr < 32'd64));
        if (addr < 32'd64) check({tag, "_grant_addr"}, mem_address, addr);
      end
      if (aux_ack === 1'b1) got = 1;
    end
    check({tag, "_ack_latency"}, 32'(cyc), 32'd2);
    if (got) sb_pop_check(tag);
    aux_req = 1'b0;
    nxt();
    @(negedge clock);
    check({tag, "_ack_width"}, 32'(aux_ack), 32'd0);
  endtask

  initial begin
    init_mem = 1'b1; reset = 1'b1;
    cpu_address = 32'd7; cpu_write_data = '0; cpu_write_enable = 1'b0; cpu_read_enable = 1'b0;
    aux_req = 1'b0; aux_address = '0; aux_write_data = '0; aux_write_enable = 1'b0;

    // Reset state
    @(posedge clock);
    @(negedge clock);
    check("rst_ack",   32'(aux_ack),   32'd0);
    check("rst_err",   32'(aux_error), 32'd0);
    check("rst_rdata", aux_read_data,  32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_pass_addr", mem_address, 32'd7);
    init_mem = 1'b0; reset = 1'b0;

    // Aux write with CPU idle, then CPU reads it back
    aux_idle("t1", 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    cpu_read_enable = 1'b1; cpu_address = 32'd5;
    #1;
    check("t1_cpu_read", cpu_read_data, 32'hDEAD_BEEF);
    cpu_read_enable = 1'b0;

    // Starvation: CPU loads every cycle, aux read of word 3 is forced after 8 cycles
    nxt();
    cpu_read_enable = 1'b1; cpu_address = 32'd10;
    aux_req = 1'b1; aux_write_enable = 1'b0; aux_address = 32'd3;
    sb.push_back('{32'h0000_1234, 1'b0});
    nxt();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("t2_no_stall", 32'(cpu_stall), 32'd0);
      check("t2_cpu_port", mem_address, 32'd10);
      check("t2_no_ack", 32'(aux_ack), 32'd0);
      nxt();
    end
    @(negedge clock);
    check("t2_forced_stall", 32'(cpu_stall), 32'd1);
    check("t2_forced_addr", mem_address, 32'd3);
    nxt();
    @(negedge clock);
    check("t2_ack", 32'(aux_ack), 32'd1);
    check("t2_stall_released", 32'(cpu_stall), 32'd0);
    sb_pop_check("t2");
    aux_req = 1'b0;

    // CPU stores every other cycle: aux read takes the first idle cycle
    nxt();
    cpu_read_enable = 1'b0; cpu_write_enable = 1'b0;
    cpu_address = 32'd20; cpu_write_data = 32'h0000_00AA;
    aux_req = 1'b1; aux_write_enable = 1'b0; aux_address = 32'd7;
    sb.push_back('{32'hA500_0007, 1'b0});
    nxt();
    cpu_write_enable = 1'b1;
    @(negedge clock);
    check("t3_cpu_keeps_port", mem_address, 32'd20);
    check("t3_no_stall_a", 32'(cpu_stall), 32'd0);
    nxt();
    cpu_write_enable = 1'b0;
    @(negedge clock);
    check("t3_grant_addr", mem_address, 32'd7);
    check("t3_no_stall_b", 32'(cpu_stall), 32'd0);
    nxt();
    cpu_write_enable = 1'b1;
    @(negedge clock);
    check("t3_ack", 32'(aux_ack), 32'd1);
    check("t3_no_stall_c", 32'(cpu_stall), 32'd0);
    sb_pop_check("t3");
    aux_req = 1'b0;
    nxt();
    cpu_write_enable = 1'b0;

    // Out-of-range aux write while CPU loads: immediate grant, no write, no stall
    cpu_read_enable = 1'b1; cpu_address = 32'd10;
    aux_req = 1'b1; aux_write_enable = 1'b1; aux_address = 32'd70; aux_write_data = 32'h55;
    sb.push_back('{32'hA500_0007, 1'b1});
    nxt();
    @(negedge clock);
    check("t4_no_we", 32'(mem_write_enable), 32'd0);
    check("t4_no_stall", 32'(cpu_stall), 32'd0);
    nxt();
    @(negedge clock);
    check("t4_ack", 32'(aux_ack), 32'd1);
    sb_pop_check("t4");
    aux_req = 1'b0;
    cpu_read_enable = 1'b0;

    // Address boundary around DEPTH
    aux_idle("t4b_64", 1'b1, 32'd64, 32'h1111_2222, 32'hA500_0007, 1'b1);
    aux_idle("t4c_63w", 1'b1, 32'd63, 32'h0BAD_F00D, 32'hA500_0007, 1'b0);
    aux_idle("t4d_63r", 1'b0, 32'd63, 32'd0, 32'h0BAD_F00D, 1'b0);

    // aux_req held high: one access per three cycles
    nxt();
    aux_req = 1'b1; aux_write_enable = 1'b0; aux_address = 32'd3;
    for (int i = 0; i < 3; i++) sb.push_back('{32'h0000_1234, 1'b0});
    for (int c = 0; c < 9; c++) begin
      nxt();
      @(negedge clock);
      if (c == 1 || c == 4 || c == 7) begin
        check($sformatf("t5_ack_c%0d", c + 1), 32'(aux_ack), 32'd1);
        sb_pop_check($sformatf("t5_c%0d", c + 1));
      end else begin
        check($sformatf("t5_noack_c%0d", c + 1), 32'(aux_ack), 32'd0);
      end
    end
    aux_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nxt();
      @(negedge clock);
      check("t5_quiet", 32'(aux_ack), 32'd0);
    end

    // Reset during a forced aux write grant
    nxt();
    cpu_read_enable = 1'b1; cpu_address = 32'd10;
    aux_req = 1'b1; aux_write_enable = 1'b1; aux_address = 32'd9; aux_write_data = 32'hCAFE_F00D;
    nxt();
    for (int i = 0; i < 8; i++) nxt();
    @(negedge clock);
    check("t6_forced_pending", 32'(cpu_stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_stall", 32'(cpu_stall), 32'd0);
    check("t6_rst_we", 32'(mem_write_enable), 32'd0);
    check("t6_rst_ack", 32'(aux_ack), 32'd0);
    check("t6_rst_err", 32'(aux_error), 32'd0);
    check("t6_rst_rdata", aux_read_data, 32'd0);
    aux_req = 1'b0;
    nxt();
    nxt();
    @(negedge clock);
    check("t6_rst_hold_ack", 32'(aux_ack), 32'd0);
    check("t6_mem9_intact", mem[9], 32'hA500_0009);
    reset = 1'b0;
    cpu_read_enable = 1'b0;
    aux_idle("t6_after", 1'b0, 32'd9, 32'd0, 32'hA500_0009, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
